sound_scheduler: RTL and testbench

SOUND_SCHEDULER -- requirements
Module: sound_scheduler

---
 rtl/sound_scheduler.sv | 133 +++++++++++++
 tb/tb_sound_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - priority scheduler feeding sound codes to the piezo player
// Grants die > eat > music, latches one-shot requests and lets strictly higher requests cut in.
module sound_scheduler #(
    parameter int unsigned TACT_CYCLES = 4194304,
    parameter int unsigned LEN_MUSIC   = 102,
    parameter int unsigned LEN_EAT     = 2,
    parameter int unsigned LEN_DIE     = 9,
    parameter int unsigned GAP_CYCLES  = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_eat,
    input  logic       req_die,
    input  logic       music_en,
    input  logic       mute,
    output logic [1:0] sound_code,
    output logic       inp_call,
    output logic       busy,
    output logic       preempted
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    localparam logic [22:0] TACT_LAST  = 23'(TACT_CYCLES - 1);
    localparam logic [22:0] GAP_LAST   = 23'(GAP_CYCLES - 1);
    localparam logic [6:0]  LAST_MUSIC = 7'(LEN_MUSIC - 1);
    localparam logic [6:0]  LAST_EAT   = 7'(LEN_EAT - 1);
    localparam logic [6:0]  LAST_DIE   = 7'(LEN_DIE - 1);

    state_t      state_q;
    logic [1:0]  code_q;
    logic        call_q;
    logic        pre_q;
    logic        pend_die_q;
    logic        pend_eat_q;
    logic [22:0] cyc_q;
    logic [6:0]  tact_q;

    logic        want_die;
    logic        want_eat;
    logic        have_req;
    logic [1:0]  req_code;
    logic [1:0]  grant_code;
    logic [6:0]  last_tact;
    logic        tact_end;
    logic        play_end;
    logic        grant;

    // Code value doubles as priority: die=2 > eat=1 > music=0.
    always_comb begin
        want_die   = pend_die_q | req_die;
        want_eat   = pend_eat_q | req_eat;
        have_req   = want_die | want_eat;
        req_code   = want_die ? 2'd2 : 2'd1;
        grant_code = have_req ? req_code : 2'd0;
        case (code_q)
            2'd2:    last_tact = LAST_DIE;
            2'd1:    last_tact = LAST_EAT;
            default: last_tact = LAST_MUSIC;
        endcase
        tact_end = (cyc_q == TACT_LAST);
        play_end = tact_end && (tact_q == last_tact);
        grant    = 1'b0;
        if (!mute) begin
            if (state_q == S_IDLE)
                grant = have_req | music_en;
            else if (state_q == S_PLAY)
                grant = !play_end && have_req && (req_code > code_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            code_q     <= 2'd0;
            call_q     <= 1'b0;
            pre_q      <= 1'b0;
            pend_die_q <= 1'b0;
            pend_eat_q <= 1'b0;
            cyc_q      <= 23'd0;
            tact_q     <= 7'd0;
        end else begin
            pre_q      <= 1'b0;
            pend_die_q <= want_die;
            pend_eat_q <= want_eat;
            if (grant) begin
                state_q <= S_PLAY;
                code_q  <= grant_code;
                call_q  <= ~call_q;
                pre_q   <= (state_q == S_PLAY);
                cyc_q   <= 23'd0;
                tact_q  <= 7'd0;
                if (want_die)
                    pend_die_q <= 1'b0;
                else if (want_eat)
                    pend_eat_q <= 1'b0;
            end else begin
                case (state_q)
                    S_PLAY: begin
                        if (play_end) begin
                            state_q <= S_GAP;
                            cyc_q   <= 23'd0;
                            tact_q  <= 7'd0;
                        end else if (tact_end) begin
                            cyc_q  <= 23'd0;
                            tact_q <= tact_q + 7'd1;
                        end else begin
                            cyc_q <= cyc_q + 23'd1;
                        end
                    end
                    S_GAP: begin
                        if (cyc_q == GAP_LAST) begin
                            state_q <= S_IDLE;
                            cyc_q   <= 23'd0;
                        end else begin
                            cyc_q <= cyc_q + 23'd1;
                        end
                    end
                    default: begin
                        cyc_q  <= 23'd0;
                        tact_q <= 7'd0;
                    end
                endcase
            end
        end
    end

    assign sound_code = code_q;
    assign inp_call   = call_q;
    assign preempted  = pre_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sound_scheduler.sv
// tb/tb_sound_scheduler.sv - directed and random stimulus against a remaining-time model
module tb_sound_scheduler;

    localparam int T   = 4;
    localparam int LM  = 5;
    localparam int LE  = 2;
    localparam int LD  = 3;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_eat = 1'b0;
    logic       req_die = 1'b0;
    logic       music_en = 1'b0;
    logic       mute = 1'b0;
    logic [1:0] sound_code;
    logic       inp_call;
    logic       busy;
    logic       preempted;

    int n_cmp = 0;
    int n_err = 0;

    int m_phase = 0;
    int m_left  = 0;
    int m_gleft = 0;
    int m_code  = 0;
    int m_call  = 0;
    int m_pre   = 0;
    int m_pd    = 0;
    int m_pe    = 0;

    sound_scheduler #(
        .TACT_CYCLES(T), .LEN_MUSIC(LM), .LEN_EAT(LE), .LEN_DIE(LD), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .req_eat(req_eat), .req_die(req_die),
        .music_en(music_en), .mute(mute), .sound_code(sound_code),
        .inp_call(inp_call), .busy(busy), .preempted(preempted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int len_of(input int code);
        return (code == 2) ? LD * T : (code == 1) ? LE * T : LM * T;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_gleft = 0; m_code = 0;
        m_call = 0; m_pre = 0; m_pd = 0; m_pe = 0;
    endtask

    task automatic model_grant(input int code);
        m_code  = code;
        m_call  = 1 - m_call;
        m_left  = len_of(code);
        m_phase = 1;
        if (code == 2) m_pd = 0;
        else if (code == 1) m_pe = 0;
    endtask

    task automatic model_step();
        int wd, we, best;
        wd = m_pd | int'(req_die);
        we = m_pe | int'(req_eat);
        m_pd = wd;
        m_pe = we;
        m_pre = 0;
        best = wd ? 2 : (we ? 1 : 0);
        if (m_phase == 0) begin
            if (!mute && (wd || we || music_en)) model_grant(best);
        end else if (m_phase == 1) begin
            if (m_left == 1) begin
                m_phase = 2;
                m_gleft = GAP;
            end else if (!mute && (wd || we) && best > m_code) begin
                model_grant(best);
                m_pre = 1;
            end else begin
                m_left--;
            end
        end else begin
            if (m_gleft == 1) m_phase = 0;
            else m_gleft--;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".code"}, int'(sound_code), m_code);
        check({tag, ".call"}, int'(inp_call), m_call);
        check({tag, ".busy"}, int'(busy), (m_phase != 0) ? 1 : 0);
        check({tag, ".pre"}, int'(preempted), m_pre);
    endtask

    task automatic step(input string tag, input logic re, input logic rd,
                        input logic men, input logic mu);
        @(negedge clk);
        req_eat = re; req_die = rd; music_en = men; mute = mu;
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        req_eat = 1'b0; req_die = 1'b0; music_en = 1'b0; mute = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt, toggles, prev_call;
        logic men, mu;

        model_reset();
        #1;
        compare_all("reset");
        do_reset("reset2");

        // single eat: busy exactly LE*T + GAP clocks
        busy_cnt = 0;
        step("eat", 1, 0, 0, 0);
        busy_cnt += int'(busy);
        for (int i = 0; i < 12; i++) begin
            step("eat_run", 0, 0, 0, 0);
            busy_cnt += int'(busy);
        end
        check("eat_busy_len", busy_cnt, LE * T + GAP);

        // music preempted by die at tact 2, then music regrants
        do_reset("rst_pre");
        for (int i = 0; i < 9; i++) step("music", 0, 0, 1, 0);
        step("die_pre", 0, 1, 1, 0);
        check("pre_pulse", int'(preempted), 1);
        for (int i = 0; i < 20; i++) step("after_pre", 0, 0, 1, 0);

        // simultaneous requests: die then eat, two toggles
        do_reset("rst_sim");
        prev_call = int'(inp_call);
        toggles = 0;
        step("sim", 1, 1, 0, 0);
        check("sim_code", int'(sound_code), 2);
        if (int'(inp_call) != prev_call) toggles++;
        prev_call = int'(inp_call);
        for (int i = 0; i < 30; i++) begin
            step("sim_run", 0, 0, 0, 0);
            if (int'(inp_call) != prev_call) toggles++;
            prev_call = int'(inp_call);
        end
        check("sim_toggles", toggles, 2);

        // mute holds the request until released
        do_reset("rst_mute");
        step("mute_req", 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("mute_hold", 0, 0, 0, 1);
        check("mute_busy", int'(busy), 0);
        step("unmute", 0, 0, 0, 0);
        check("unmute_code", int'(sound_code), 1);
        for (int i = 0; i < 12; i++) step("unmute_run", 0, 0, 0, 0);

        // reset mid-die aborts with no further toggle
        do_reset("rst_mid0");
        step("die", 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step("die_run", 0, 0, 0, 0);
        do_reset("rst_mid");
        for (int i = 0; i < 4; i++) step("post_rst", 0, 0, 0, 0);

        // same-priority request waits for GAP
        do_reset("rst_low");
        step("eat1", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("eat1_run", 0, 0, 0, 0);
        step("eat2", 1, 0, 0, 0);
        for (int i = 0; i < 25; i++) step("eat2_run", 0, 0, 0, 0);

        // random traffic
        do_reset("rst_rand");
        men = 1'b0;
        mu = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) men = ~men;
            if ($urandom_range(0, 29) == 0) mu = ~mu;
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rand_rst");
                men = 1'b0;
                mu = 1'b0;
            end else begin
                step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), men, mu);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
